// File: rtl/counter_sequencer.sv
// Four-mode (stop/up/down/bounce) LED counter sequencer driven by three debounced switches.
// Optional macro SEQ_WRAP_PULSE_EN adds the o_Wrap boundary-crossing pulse output.
module counter_sequencer #(
  parameter int HALF_SECOND = 12_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Mode_Sw,
  input  logic       i_Speed_Sw,
  input  logic       i_Clear_Sw,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode,
`ifdef SEQ_WRAP_PULSE_EN
  output logic       o_Wrap,
`endif
  output logic [1:0] o_Speed
);

  localparam int DIV_W = $clog2(HALF_SECOND);
  localparam logic [DIV_W-1:0] PER0_M1 = DIV_W'(HALF_SECOND - 1);
  localparam logic [DIV_W-1:0] PER1_M1 = DIV_W'((HALF_SECOND >> 1) - 1);
  localparam logic [DIV_W-1:0] PER2_M1 = DIV_W'((HALF_SECOND >> 2) - 1);
  localparam logic [DIV_W-1:0] PER3_M1 = DIV_W'((HALF_SECOND >> 3) - 1);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_BOUNCE = 2'd3
  } mode_e;

  logic             mode_hist_r, speed_hist_r, clear_hist_r;
  logic             mode_press_s, speed_press_s, clear_press_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] period_m1_s;
  logic             tick_r;
  logic [1:0]       speed_r;
  mode_e            state_r;
  mode_e            next_state_s;
  logic [3:0]       cnt_r;
  logic [3:0]       step_cnt_s;
  logic             dir_r;
  logic             step_dir_s;

  assign mode_press_s  = i_Mode_Sw  & ~mode_hist_r;
  assign speed_press_s = i_Speed_Sw & ~speed_hist_r;
  assign clear_press_s = i_Clear_Sw & ~clear_hist_r;
  assign next_state_s  = mode_e'(state_r + 2'd1);

  // Switch history; resets high so a switch held through reset is not a press.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mode_hist_r  <= 1'b1;
      speed_hist_r <= 1'b1;
      clear_hist_r <= 1'b1;
    end else begin
      mode_hist_r  <= i_Mode_Sw;
      speed_hist_r <= i_Speed_Sw;
      clear_hist_r <= i_Clear_Sw;
    end
  end

  // Terminal divider count for the selected speed.
  always_comb begin
    period_m1_s = PER0_M1;
    case (speed_r)
      2'd0:    period_m1_s = PER0_M1;
      2'd1:    period_m1_s = PER1_M1;
      2'd2:    period_m1_s = PER2_M1;
      default: period_m1_s = PER3_M1;
    endcase
  end

  // Rate divider, one-cycle tick and speed index.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      div_r   <= '0;
      tick_r  <= 1'b0;
      speed_r <= 2'd0;
    end else begin
      if (speed_press_s) begin
        speed_r <= speed_r + 2'd1;
      end
      if (speed_press_s || clear_press_s) begin
        div_r  <= '0;
        tick_r <= 1'b0;
      end else if (div_r == period_m1_s) begin
        div_r  <= '0;
        tick_r <= 1'b1;
      end else begin
        div_r  <= div_r + DIV_W'(1);
        tick_r <= 1'b0;
      end
    end
  end

  // Next count and bounce direction for a step in the current mode.
  always_comb begin
    step_cnt_s = cnt_r;
    step_dir_s = dir_r;
    case (state_r)
      ST_UP:   step_cnt_s = cnt_r + 4'd1;
      ST_DOWN: step_cnt_s = cnt_r - 4'd1;
      ST_BOUNCE: begin
        if (dir_r) begin
          if (cnt_r == 4'd15) begin
            step_cnt_s = 4'd14;
            step_dir_s = 1'b0;
          end else begin
            step_cnt_s = cnt_r + 4'd1;
          end
        end else begin
          if (cnt_r == 4'd0) begin
            step_cnt_s = 4'd1;
            step_dir_s = 1'b1;
          end else begin
            step_cnt_s = cnt_r - 4'd1;
          end
        end
      end
      default: begin
        step_cnt_s = cnt_r;
        step_dir_s = dir_r;
      end
    endcase
  end

  // Mode FSM and counter; clear and mode presses both take precedence over a tick.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= ST_STOP;
      cnt_r   <= 4'd0;
      dir_r   <= 1'b1;
    end else begin
      if (mode_press_s) begin
        state_r <= next_state_s;
      end
      if (clear_press_s) begin
        cnt_r <= 4'd0;
        dir_r <= 1'b1;
      end else if (mode_press_s) begin
        if (next_state_s == ST_BOUNCE) begin
          dir_r <= 1'b1;
        end
      end else if (tick_r) begin
        cnt_r <= step_cnt_s;
        dir_r <= step_dir_s;
      end
    end
  end

`ifdef SEQ_WRAP_PULSE_EN
  logic wrap_r;
  logic step_wrap_s;

  assign step_wrap_s = ((state_r == ST_UP)     && (cnt_r == 4'd15)) ||
                       ((state_r == ST_DOWN)   && (cnt_r == 4'd0))  ||
                       ((state_r == ST_BOUNCE) && dir_r  && (cnt_r == 4'd15)) ||
                       ((state_r == ST_BOUNCE) && !dir_r && (cnt_r == 4'd0));

  // Boundary pulse, raised only on edges where a step is actually applied.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= tick_r & ~mode_press_s & ~clear_press_s & step_wrap_s;
    end
  end

  assign o_Wrap = wrap_r;
`endif

  assign o_LED_1 = cnt_r[3];
  assign o_LED_2 = cnt_r[2];
  assign o_LED_3 = cnt_r[1];
  assign o_LED_4 = cnt_r[0];
  assign o_Mode  = state_r;
  assign o_Speed = speed_r;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with HALF_SECOND=8; wrap checks run when SEQ_WRAP_PULSE_EN is defined.
module tb_counter_sequencer;

  logic       clk;
  logic       rst_n;
  logic       mode_sw, speed_sw, clear_sw;
  logic       led1, led2, led3, led4;
  logic [1:0] mode_o, speed_o;
  logic [3:0] leds_s;
  int         vec_cnt;
  int         err_cnt;
`ifdef SEQ_WRAP_PULSE_EN
  logic       wrap_o;
  int         wrap_cnt;
`endif

  counter_sequencer #(.HALF_SECOND(8)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Mode_Sw  (mode_sw),
    .i_Speed_Sw (speed_sw),
    .i_Clear_Sw (clear_sw),
    .o_LED_1    (led1),
    .o_LED_2    (led2),
    .o_LED_3    (led3),
    .o_LED_4    (led4),
    .o_Mode     (mode_o),
`ifdef SEQ_WRAP_PULSE_EN
    .o_Wrap     (wrap_o),
`endif
    .o_Speed    (speed_o)
  );

  assign leds_s = {led1, led2, led3, led4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_WRAP_PULSE_EN
  initial wrap_cnt = 0;
  always @(negedge clk) if (wrap_o === 1'b1) wrap_cnt++;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Switches are high for exactly one edge; returns just after that edge.
  task automatic press(input logic m, input logic s, input logic c);
    mode_sw = m; speed_sw = s; clear_sw = c;
    @(posedge clk); #1;
    mode_sw = 1'b0; speed_sw = 1'b0; clear_sw = 1'b0;
  endtask

  // n = edges until the LEDs change, or -1 after 200 edges.
  task automatic wait_change(output int n);
    logic [3:0] prev;
    prev = leds_s;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (leds_s !== prev) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mode_sw = 1'b1; speed_sw = 1'b0; clear_sw = 1'b0;
    cycles(3);
    vec_cnt++; if (leds_s !== 4'd0) begin err_cnt++; $display("FAIL reset_leds: got %0d want 0", leds_s); end
    vec_cnt++; if (mode_o !== 2'd0) begin err_cnt++; $display("FAIL reset_mode: got %0d want 0", mode_o); end
    vec_cnt++; if (speed_o !== 2'd0) begin err_cnt++; $display("FAIL reset_speed: got %0d want 0", speed_o); end
`ifdef SEQ_WRAP_PULSE_EN
    vec_cnt++; if (wrap_o !== 1'b0) begin err_cnt++; $display("FAIL reset_wrap: got %0b want 0", wrap_o); end
`endif
    rst_n = 1'b1;
    cycles(3);
    vec_cnt++; if (mode_o !== 2'd0) begin err_cnt++; $display("FAIL held_mode_sw: got %0d want 0", mode_o); end
    mode_sw = 1'b0;
    cycles(1);
    vec_cnt++; if (mode_o !== 2'd0) begin err_cnt++; $display("FAIL mode_sw_release: got %0d want 0", mode_o); end
  endtask

  task automatic test_up;
    int n;
    logic [3:0] exp;
    press(1'b1, 1'b0, 1'b0);
    vec_cnt++; if (mode_o !== 2'd1) begin err_cnt++; $display("FAIL up_mode: got %0d want 1", mode_o); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd1 || n < 1 || n > 9) begin err_cnt++; $display("FAIL up_first: got %0d after %0d want 1 within 9", leds_s, n); end
    for (int k = 2; k <= 16; k++) begin
      exp = k[3:0];
      wait_change(n);
      vec_cnt++; if (leds_s !== exp || n !== 8) begin err_cnt++; $display("FAIL up_step: got %0d after %0d want %0d after 8", leds_s, n, exp); end
    end
`ifdef SEQ_WRAP_PULSE_EN
    vec_cnt++; if (wrap_o !== 1'b1) begin err_cnt++; $display("FAIL up_wrap_pulse: got %0b want 1", wrap_o); end
    cycles(1);
    vec_cnt++; if (wrap_o !== 1'b0) begin err_cnt++; $display("FAIL up_wrap_end: got %0b want 0", wrap_o); end
`endif
  endtask

  task automatic test_speed;
    int n;
    logic [3:0] exp;
    for (int k = 1; k <= 5; k++) begin
      exp = k[3:0];
      wait_change(n);
      vec_cnt++; if (leds_s !== exp) begin err_cnt++; $display("FAIL speed_lead_in: got %0d want %0d", leds_s, exp); end
    end
    press(1'b0, 1'b1, 1'b0); cycles(1);
    press(1'b0, 1'b1, 1'b0); cycles(1);
    press(1'b0, 1'b1, 1'b0);
    vec_cnt++; if (speed_o !== 2'd3 || leds_s !== 4'd5) begin err_cnt++; $display("FAIL speed3: got speed %0d leds %0d want 3 and 5", speed_o, leds_s); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd6 || n !== 2) begin err_cnt++; $display("FAIL speed3_first: got %0d after %0d want 6 after 2", leds_s, n); end
    for (int k = 7; k <= 8; k++) begin
      exp = k[3:0];
      wait_change(n);
      vec_cnt++; if (leds_s !== exp || n !== 1) begin err_cnt++; $display("FAIL speed3_step: got %0d after %0d want %0d after 1", leds_s, n, exp); end
    end
    // A tick is pending on this press edge, so the count still advances to 9.
    press(1'b0, 1'b1, 1'b0);
    vec_cnt++; if (speed_o !== 2'd0 || leds_s !== 4'd9) begin err_cnt++; $display("FAIL speed_wrap: got speed %0d leds %0d want 0 and 9", speed_o, leds_s); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd10 || n !== 9) begin err_cnt++; $display("FAIL speed0_first: got %0d after %0d want 10 after 9", leds_s, n); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd11 || n !== 8) begin err_cnt++; $display("FAIL speed0_step: got %0d after %0d want 11 after 8", leds_s, n); end
  endtask

  task automatic test_clear;
    int n;
    int w0;
    for (int i = 0; i < 20; i++) begin
      wait_change(n);
      if (leds_s == 4'd9) break;
    end
    vec_cnt++; if (leds_s !== 4'd9) begin err_cnt++; $display("FAIL clear_reach9: got %0d want 9", leds_s); end
    cycles(7);
    w0 = 0;
`ifdef SEQ_WRAP_PULSE_EN
    w0 = wrap_cnt;
`endif
    press(1'b0, 1'b0, 1'b1);
    vec_cnt++; if (leds_s !== 4'd0 || mode_o !== 2'd1) begin err_cnt++; $display("FAIL clear_on_tick: got leds %0d mode %0d want 0 and 1", leds_s, mode_o); end
    // Divider restarts on the clear edge: tick P edges later, step one edge after.
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd1 || n !== 9) begin err_cnt++; $display("FAIL clear_next: got %0d after %0d want 1 after 9", leds_s, n); end
`ifdef SEQ_WRAP_PULSE_EN
    vec_cnt++; if (wrap_cnt !== w0) begin err_cnt++; $display("FAIL clear_no_wrap: got %0d pulses want %0d", wrap_cnt, w0); end
`endif
  endtask

  task automatic test_down;
    int n;
    press(1'b1, 1'b0, 1'b1);
    vec_cnt++; if (leds_s !== 4'd0 || mode_o !== 2'd2) begin err_cnt++; $display("FAIL clear_mode_same: got leds %0d mode %0d want 0 and 2", leds_s, mode_o); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd15 || n !== 9) begin err_cnt++; $display("FAIL down_wrap: got %0d after %0d want 15 after 9", leds_s, n); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd14 || n !== 8) begin err_cnt++; $display("FAIL down_step: got %0d after %0d want 14 after 8", leds_s, n); end
  endtask

  task automatic test_bounce;
    int n;
    logic [3:0] exp;
    cycles(7);
    press(1'b1, 1'b0, 1'b0);
    vec_cnt++; if (mode_o !== 2'd3 || leds_s !== 4'd14) begin err_cnt++; $display("FAIL mode_on_tick: got mode %0d leds %0d want 3 and 14", mode_o, leds_s); end
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) exp = 4'd15;
      else if (k <= 15) exp = 4'(15 - k);
      else exp = 4'd1;
      wait_change(n);
      vec_cnt++; if (leds_s !== exp || n !== 8) begin err_cnt++; $display("FAIL bounce_step%0d: got %0d after %0d want %0d after 8", k, leds_s, n, exp); end
    end
  endtask

  task automatic test_mode_speed_same;
    press(1'b1, 1'b1, 1'b0);
    vec_cnt++; if (mode_o !== 2'd0 || speed_o !== 2'd1 || leds_s !== 4'd1) begin err_cnt++; $display("FAIL mode_speed_same: got mode %0d speed %0d leds %0d want 0 1 1", mode_o, speed_o, leds_s); end
    cycles(20);
    vec_cnt++; if (leds_s !== 4'd1) begin err_cnt++; $display("FAIL stop_hold: got %0d want 1", leds_s); end
  endtask

  task automatic test_reset_mid;
    int n;
    press(1'b1, 1'b0, 1'b0);
    vec_cnt++; if (mode_o !== 2'd1) begin err_cnt++; $display("FAIL mid_up_mode: got %0d want 1", mode_o); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd2 || n < 1 || n > 5) begin err_cnt++; $display("FAIL mid_step: got %0d after %0d want 2 within 5", leds_s, n); end
    #3 rst_n = 1'b0;
    #1;
    vec_cnt++; if (leds_s !== 4'd0 || mode_o !== 2'd0 || speed_o !== 2'd0) begin err_cnt++; $display("FAIL async_reset: got leds %0d mode %0d speed %0d want 0 0 0", leds_s, mode_o, speed_o); end
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    press(1'b1, 1'b0, 1'b0);
    vec_cnt++; if (mode_o !== 2'd1 || speed_o !== 2'd0) begin err_cnt++; $display("FAIL post_reset_mode: got mode %0d speed %0d want 1 0", mode_o, speed_o); end
    wait_change(n);
    vec_cnt++; if (leds_s !== 4'd1 || n !== 7) begin err_cnt++; $display("FAIL post_reset_step: got %0d after %0d want 1 after 7", leds_s, n); end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset;
    test_up;
    test_speed;
    test_clear;
    test_down;
    test_bounce;
    test_mode_speed_same;
    test_reset_mid;
`ifdef SEQ_WRAP_PULSE_EN
    vec_cnt++; if (wrap_cnt !== 5) begin err_cnt++; $display("FAIL wrap_total: got %0d pulse cycles want 5", wrap_cnt); end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
